execute_muldiv_ctrl: RTL and testbench

EXECUTE_MULDIV_CTRL -- requirements
Module: execute_muldiv_ctrl

---
 rtl/execute_muldiv_ctrl.sv | 109 ++++++++++
 tb/tb_execute_muldiv_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_ctrl.sv
// Iterative Execute-stage multiply/divide unit: 32-cycle unsigned shift-add multiply
// and restoring divide, with pipeline stall and flush handling.
module execute_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic [1:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallMD,
  output logic        BusyE,
  output logic        MDValidE,
  output logic [31:0] MDResultE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_opb;
  logic [63:0] r_prod;
  logic [31:0] r_result;

  logic        w_start;
  logic        w_div_zero;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_iter_next;
  logic [31:0] w_final;

  assign w_start    = StartE & ~FlushE;
  assign w_div_zero = MulDivOpE[1] & (SrcBE == 32'd0);

  // Multiply: {hi, lo} with the multiplier in lo; add multiplicand to hi, shift right.
  assign w_mul_sum  = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_prod[31:1]};

  // Divide: {remainder, dividend/quotient}; shift left, trial-subtract, restore on borrow.
  assign w_div_shift = {r_prod[63:32], r_prod[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_prod[30:0], 1'b0}
                                      : {w_div_diff[31:0],  r_prod[30:0], 1'b1};

  assign w_iter_next = r_op[1] ? w_div_next : w_mul_next;
  // Low half holds product-low / quotient, high half product-high / remainder.
  assign w_final     = r_op[0] ? w_iter_next[63:32] : w_iter_next[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_op     <= 2'd0;
      r_opb    <= 32'd0;
      r_prod   <= 64'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op   <= MulDivOpE;
            r_opb  <= MulDivOpE[1] ? SrcBE : SrcAE;
            r_prod <= {32'd0, MulDivOpE[1] ? SrcAE : SrcBE};
            r_cnt  <= 5'd0;
            if (w_div_zero) begin
              r_result <= MulDivOpE[0] ? SrcAE : 32'hFFFF_FFFF;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (FlushE) begin
            r_state <= S_IDLE;
          end else begin
            r_prod <= w_iter_next;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= w_final;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall must act in the op's first Execute cycle, so it is decoded from inputs.
  always_comb begin
    StallMD = 1'b0;
    case (r_state)
      S_IDLE:  StallMD = w_start;
      S_RUN:   StallMD = ~FlushE;
      default: StallMD = 1'b0;
    endcase
  end

  assign BusyE     = (r_state == S_RUN);
  assign MDValidE  = (r_state == S_DONE) & ~FlushE;
  assign MDResultE = r_result;

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Scoreboard bench for execute_muldiv_ctrl: random and directed mul/div ops checked
// against an arithmetic reference model, plus flush and asynchronous reset cases.
module tb_execute_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StartE = 1'b0;
  logic [1:0]  MulDivOpE = 2'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        FlushE = 1'b0;
  logic        StallMD;
  logic        BusyE;
  logic        MDValidE;
  logic [31:0] MDResultE;

  execute_muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .FlushE    (FlushE),
    .StallMD   (StallMD),
    .BusyE     (BusyE),
    .MDValidE  (MDValidE),
    .MDResultE (MDResultE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Called just after a rising edge; holds StartE until the edge that ends DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    int          c0;
    int          bad;
    logic [31:0] e;
    logic        es;
    logic        eb;
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    c0  = cyc;
    bad = 0;
    e   = model(op, a, b);
    check32("hold_result", MDResultE, last_res);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
    sb.push_back('{res: e, at: c0 + lat});
    for (int d = 0; d <= lat; d++) begin
      @(negedge clk);
      es = (d < lat);
      eb = (d >= 1) && (d < lat);
      if (StallMD !== es || BusyE !== eb) begin
        bad++;
        $display("FAIL stall_busy: op %0d cycle +%0d got stall %b busy %b expected %b %b",
                 op, d, StallMD, BusyE, es, eb);
      end
      @(posedge clk); #1;
      SrcAE = $urandom; SrcBE = $urandom;
    end
    StartE = 1'b0;
    checks++;
    if (bad != 0) errors++;
    last_res = e;
  endtask

  task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b | 32'd1;
    for (int d = 0; d <= 10; d++) begin
      @(posedge clk); #1;
    end
    check32("flush_busy_before", {31'd0, BusyE}, 32'd1);
    FlushE = 1'b1;
    #1;
    check32("flush_stall_drop", {31'd0, StallMD}, 32'd0);
    @(posedge clk); #1;
    FlushE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    check32("flush_busy_after", {31'd0, BusyE}, 32'd0);
    check32("flush_no_valid", {31'd0, MDValidE}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_stall"},  {31'd0, StallMD},  32'd0);
    check32({tag, "_busy"},   {31'd0, BusyE},    32'd0);
    check32({tag, "_valid"},  {31'd0, MDValidE}, 32'd0);
    check32({tag, "_result"}, MDResultE,         32'd0);
  endtask

  initial begin
    exp_t        x;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    fork
      forever begin
        @(negedge clk);
        if (rst && MDValidE) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got result %h at cycle %0d expected no pulse", MDResultE, cyc);
          end else begin
            x = sb.pop_front();
            check32("result", MDResultE, x.res);
            check32("latency", 32'(cyc), 32'(x.at));
          end
        end
      end
    join_none

    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    run_op(2'd0, 32'd7, 32'd6);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd2, 32'h1234, 32'd0);
    run_op(2'd3, 32'h1234, 32'd0);

    flush_op(2'd2, $urandom, $urandom);
    run_op(2'd2, 32'hDEAD_BEEF, 32'd13);

    // Reset mid-RUN at iteration 20, then a fresh multiply.
    StartE = 1'b1; MulDivOpE = 2'd0; SrcAE = $urandom; SrcBE = $urandom;
    for (int d = 0; d <= 20; d++) begin
      @(posedge clk); #1;
    end
    #1;
    rst = 1'b0; StartE = 1'b0;
    #1;
    check_all_zero("async_reset");
    last_res = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(2'd0, 32'd3, 32'd5);

    for (int i = 0; i < 25; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb);
    end

    repeat (3) @(posedge clk);
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
